// File: rtl/sram_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_model
// Brief    : Behavioural single-port async-read board SRAM for ARM_Module sim.
//            Optional macro SRAM_MODEL_REG_READ_EN registers the read path.
// Revision : 1.0 - initial release
// ============================================================================
module sram_model #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 18,
  parameter int                DEPTH    = 65536,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] sram_dq,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_we_en
);

  localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [ADDR_W:0]    w_addr_mod;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_unused_hi;
  logic [DATA_W-1:0]  w_rd_word;
  logic [DATA_W-1:0]  w_bus_out;
  logic               w_drive;

  assign w_addr_mod  = {1'b0, sram_addr} % c_DEPTH;
  assign w_idx       = w_addr_mod[c_IDX_W-1:0];
  assign w_unused_hi = ^w_addr_mod[ADDR_W:c_IDX_W];

  // A cleared valid bit stands for INIT_VAL, so reset wipes every word at once
  // without touching the array itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (sram_we_en == 1'b0) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && (sram_we_en == 1'b0)) begin
      r_mem[w_idx] <= sram_dq;
    end
  end

  assign w_rd_word = r_valid[w_idx] ? r_mem[w_idx] : INIT_VAL;

`ifdef SRAM_MODEL_REG_READ_EN
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= INIT_VAL;
    end else if (sram_we_en == 1'b1) begin
      r_rd_data <= w_rd_word;
    end
  end

  assign w_bus_out = r_rd_data;
`else
  assign w_bus_out = w_rd_word;
`endif

  // Release the bus the moment a write or reset begins to avoid contention.
  assign w_drive = rst & sram_we_en;
  assign sram_dq = w_drive ? w_bus_out : {DATA_W{1'bz}};

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      if ({1'b0, sram_addr} >= c_DEPTH) begin
        $warning("sram_model: address 0x%h is beyond DEPTH, access aliases", sram_addr);
      end
      if ($isunknown(sram_we_en)) begin
        $warning("sram_model: sram_we_en is X/Z while out of reset");
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_model
// Brief    : Self-checking bench for sram_model; a pull-up marks a released bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_model;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 18;
  localparam int DEPTH  = 65536;
`ifdef SRAM_MODEL_REG_READ_EN
  localparam int RD_LAT = 1;
`else
  localparam int RD_LAT = 0;
`endif
  localparam logic [DATA_W-1:0] c_RELEASED = 16'hFFFF;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic              we_en    = 1'b1;
  logic              drv      = 1'b0;
  logic [DATA_W-1:0] drv_data = '0;
  logic [ADDR_W-1:0] addr     = '0;
  wire  [DATA_W-1:0] dq;

  assign dq = drv ? drv_data : {DATA_W{1'bz}};

  for (genvar i = 0; i < DATA_W; i++) begin : g_pull
    pullup pu (dq[i]);
  end

  sram_model #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_dq    (dq),
    .sram_addr  (addr),
    .sram_we_en (we_en)
  );

  always #5 clk = ~clk;

  int                passed = 0;
  int                total  = 0;
  logic [DATA_W-1:0] model [int];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    int k;
    k = int'(a) % DEPTH;
    if (model.exists(k)) return model[k];
    return 16'h0000;
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    addr = a; we_en = 1'b0; drv = 1'b1; drv_data = d;
    @(posedge clk);
    if (rst) model[int'(a) % DEPTH] = d;
    #1;
    we_en = 1'b1; drv = 1'b0;
  endtask

  // Drives a read and queues the expected word; the caller pops and compares.
  task automatic do_read(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    drv = 1'b0; we_en = 1'b1; addr = a;
    exp_q.push_back(model_rd(a));
    if (RD_LAT > 0) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    model.delete();
    we_en = 1'b1; addr = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      total++;
      if (dq !== c_RELEASED) $display("FAIL reset_z[%0d]: dq=%h expected released %h", i, dq, c_RELEASED);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b1; addr = '0; we_en = 1'b1;
    exp_q.push_back(model_rd('0));
    if (RD_LAT > 0) @(posedge clk);
    #2;
    exp_v = exp_q.pop_front();
    total++;
    if (dq !== exp_v) $display("FAIL reset_read: dq=%h expected=%h", dq, exp_v);
    else passed++;
  endtask

  task automatic test_write_readback;
    logic [ADDR_W-1:0] a_tab [2];
    a_tab[0] = 18'h00010; a_tab[1] = 18'h00011;
    do_write(a_tab[0], 16'hA5A5);
    do_write(a_tab[1], 16'h1234);
    for (int i = 0; i < 2; i++) begin
      do_read(a_tab[i]);
      exp_v = exp_q.pop_front();
      total++;
      if (dq !== exp_v) $display("FAIL readback[%0d]: addr=%h dq=%h expected=%h", i, a_tab[i], dq, exp_v);
      else passed++;
    end
  endtask

  task automatic test_turnaround;
    @(negedge clk);
    addr = 18'h00010; we_en = 1'b0; drv = 1'b0;
    #2;
    total++;
    if (dq !== c_RELEASED) $display("FAIL turn_release: dq=%h expected released %h", dq, c_RELEASED);
    else passed++;
    drv = 1'b1; drv_data = 16'h3C3C;
    #1;
    total++;
    if (dq !== 16'h3C3C) $display("FAIL turn_contention: dq=%h expected=%h", dq, 16'h3C3C);
    else passed++;
    @(posedge clk);
    model[int'(addr) % DEPTH] = 16'h3C3C;
    #1;
    drv = 1'b0; we_en = 1'b1;
    do_read(18'h00010);
    exp_v = exp_q.pop_front();
    total++;
    if (dq !== exp_v) $display("FAIL turn_drive: dq=%h expected=%h", dq, exp_v);
    else passed++;
  endtask

  task automatic test_alias;
    logic [ADDR_W-1:0] a_tab [2];
    a_tab[0] = 18'h00005; a_tab[1] = 18'h10005;
    do_write(18'h10005, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      do_read(a_tab[i]);
      exp_v = exp_q.pop_front();
      total++;
      if (dq !== exp_v) $display("FAIL alias[%0d]: addr=%h dq=%h expected=%h", i, a_tab[i], dq, exp_v);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    logic [ADDR_W-1:0] a_tab [3];
    a_tab[0] = 18'h00020; a_tab[1] = 18'h00021; a_tab[2] = 18'h00010;
    do_write(18'h00020, 16'h5555);
    rst = 1'b0;
    model.delete();
    @(negedge clk);
    rst = 1'b1;
    // A write attempted while reset is held must be dropped.
    @(negedge clk);
    rst = 1'b0; addr = 18'h00021; we_en = 1'b0; drv = 1'b1; drv_data = 16'h7777;
    @(posedge clk); #1;
    drv = 1'b0; we_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_read(a_tab[i]);
      exp_v = exp_q.pop_front();
      total++;
      if (dq !== exp_v) $display("FAIL reset_mid[%0d]: addr=%h dq=%h expected=%h", i, a_tab[i], dq, exp_v);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    do_write(18'h00030, 16'hCAFE);
    do_read(18'h00030);
    exp_v = exp_q.pop_front();
    total++;
    if (dq !== exp_v) $display("FAIL b2b_cafe: dq=%h expected=%h", dq, exp_v);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      a = ADDR_W'($urandom_range(0, 18'h3FFFF));
      d = DATA_W'($urandom_range(0, 16'hFFFE));
      do_write(a, d);
      do_read(a);
      exp_v = exp_q.pop_front();
      total++;
      if (dq !== exp_v) $display("FAIL b2b_rand[%0d]: addr=%h dq=%h expected=%h", i, a, dq, exp_v);
      else passed++;
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_write_readback;
    test_turnaround;
    test_alias;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_model.md
Name: sram_model

Overview:
- Behavioural single-port asynchronous-read SRAM model that stands in for the off-chip board SRAM during ARM_Module simulation.
- Connects directly to the processor's SRAM pins: shared bidirectional data bus, word address and active-low write enable.
- Chip-enable, output-enable and byte lanes are tied active by the controller, so they are not modelled.

Parameters:
- DATA_W, 16, data bus width in bits (matches `SRAM_DATA_LEN).
- ADDR_W, 18, address width in bits (matches `SRAM_ADDR_LEN).
- DEPTH, 65536, number of implemented words; must be ≤ 2**ADDR_W.
- INIT_VAL, 0, value loaded into every word at reset.

Ports:
- clk  input  1  clock; writes are captured on its rising edge.
- rst  input  1  asynchronous, active-low reset. The name follows the codebase; polarity is fixed active-low.
- sram_dq  inout  DATA_W  bidirectional data bus. Driven by this block only during reads.
- sram_addr  input  ADDR_W  word address.
- sram_we_en  input  1  active-low write enable (0 = write, 1 = read).

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_W bits. The effective index is sram_addr modulo DEPTH, so upper bits beyond log2(DEPTH) are ignored and addresses alias/wrap.
- Reset (rst=0, asynchronous):
  - All words are set to INIT_VAL.
  - sram_dq is released to high-Z immediately.
  - Writes are ignored while rst=0.
- Write: on a rising clk with rst=1 and sram_we_en=0, mem[idx] <= sram_dq.
  - Any bit of sram_dq that is Z or X is stored as-is.
  - One word is written per clock; a held write rewrites the same location each edge.
- Read, with rst=1 and sram_we_en=1:
  - sram_dq is driven combinationally with mem[idx], zero cycles of latency.
  - It follows sram_addr changes within the same delta.
- Bus turnaround:
  - sram_dq goes high-Z the instant sram_we_en falls to 0 or rst falls to 0, so there is no contention with the controller.
  - When sram_we_en rises to 1, the block drives immediately.
- Write then read of the same address on consecutive cycles returns the new data on the read cycle.
- Reset asserted mid-write: the write in progress is lost and the location holds INIT_VAL.
- When rst deasserts, a read is valid in the same cycle, provided sram_we_en=1.
- Simulation-only checks:
  - $display a warning when sram_addr ≥ DEPTH, since the access aliases.
  - $display a warning when sram_we_en is X or Z while rst=1.

Optional Feature:
- Macro: SRAM_MODEL_REG_READ_EN.
- Defined: reads are registered.
  - The read register captures mem[idx] on each rising clk while sram_we_en=1, giving 1-cycle latency.
  - sram_dq drives that register's contents.
  - The read register is reset to INIT_VAL.
  - A write to the same address is not forwarded into the register in the cycle the write occurs.
- Not defined: combinational read exactly as in Behaviour.

Test Plan:
- Reset with INIT_VAL=0:
  - Hold rst=0 for 3 cycles → sram_dq = Z throughout.
  - Release rst with we_en=1, addr=0 → sram_dq reads 0x0000.
- Write/readback:
  - Write 0xA5A5 @ addr 0x00010, then 0x1234 @ 0x00011, with we_en=0 and the bench driving dq.
  - Then read with we_en=1 and the bench at Z → 0xA5A5 and 0x1234 respectively.
- Bus turnaround: toggle we_en 1→0→1 at a fixed address → the block drives when we_en=1 and is Z when we_en=0. The resolved bus never shows X while the bench drives.
- Aliasing with DEPTH=65536:
  - Write 0xBEEF @ 0x10005 → read @ 0x00005 returns 0xBEEF.
  - The out-of-range warning is printed.
- Reset mid-operation:
  - Write 0x5555 @ 0x00020, then pulse rst=0 for one half-cycle → read @ 0x00020 returns 0x0000.
  - A write attempted during reset has no effect.
- Back-to-back: write 0xCAFE @ 0x00030 at edge N, read at cycle N+1 → 0xCAFE.
  - With SRAM_MODEL_REG_READ_EN defined, the value appears at cycle N+2.
